// File: rtl/mem_array_ctrl.sv
// Word-array access controller: takes one read/write request at a time and sequences
// the shared sel/rw/wdata strobes with one cycle of setup and hold around the sel pulse.
module mem_array_ctrl #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned WORDS  = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [WORDS-1:0]  arr_sel,
  output logic              arr_rw,
  output logic [DATA_W-1:0] arr_wdata,
  input  logic [DATA_W-1:0] arr_rdata
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ACCESS = 3'd2,
    S_HOLD   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t state;
  state_t state_next;

  logic              accept;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              in_range;

  logic              req_ready_d;
  logic              rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_d;
  logic              rsp_err_d;
  logic [WORDS-1:0]  arr_sel_d;
  logic              arr_rw_d;
  logic [DATA_W-1:0] arr_wdata_d;

  // req_ready is a registered copy of (state == IDLE)
  assign accept   = req_valid & req_ready;
  assign in_range = 32'(addr_q) < WORDS;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:   if (accept) state_next = S_SETUP;
      S_SETUP:  state_next = S_ACCESS;
      S_ACCESS: state_next = S_HOLD;
      S_HOLD:   state_next = S_RESP;
      S_RESP:   if (rsp_ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Output next-values: computed from the upcoming state so every output is a flop
  always_comb begin
    logic              lat_we;
    logic [DATA_W-1:0] lat_wdata;

    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    arr_sel_d   = '0;
    arr_rw_d    = 1'b0;
    arr_wdata_d = '0;
    lat_we      = accept ? req_we    : we_q;
    lat_wdata   = accept ? req_wdata : wdata_q;

    req_ready_d = (state_next == S_IDLE);
    rsp_valid_d = (state_next == S_RESP);

    if ((state_next == S_SETUP) || (state_next == S_ACCESS) || (state_next == S_HOLD)) begin
      arr_rw_d    = lat_we;
      arr_wdata_d = lat_wdata;
    end

    // Only SETUP leads to ACCESS, so addr_q is already latched here
    if ((state_next == S_ACCESS) && in_range) begin
      arr_sel_d = WORDS'(1) << addr_q;
    end

    // Capture on the edge leaving ACCESS; clear once the response is consumed
    if (state == S_ACCESS) begin
      rsp_err_d   = ~in_range;
      rsp_rdata_d = (!we_q && in_range) ? arr_rdata : '0;
    end else if ((state == S_RESP) && rsp_ready) begin
      rsp_err_d   = 1'b0;
      rsp_rdata_d = '0;
    end
  end

  // Output and request-latch registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      arr_sel   <= '0;
      arr_rw    <= 1'b0;
      arr_wdata <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
      arr_sel   <= arr_sel_d;
      arr_rw    <= arr_rw_d;
      arr_wdata <= arr_wdata_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_array_ctrl.sv
// Scoreboard bench for mem_array_ctrl: an array model answers the strobes, a reference
// memory predicts every response, and a negedge monitor checks timing and payload.
module tb_mem_array_ctrl;

  localparam int ADDR_W = 4;
  localparam int WORDS  = 12;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [WORDS-1:0]  arr_sel;
  logic              arr_rw;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;

  mem_array_ctrl #(.ADDR_W(ADDR_W), .WORDS(WORDS), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .arr_sel(arr_sel), .arr_rw(arr_rw), .arr_wdata(arr_wdata), .arr_rdata(arr_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              err;
    int                acc;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   hs_cyc = -100;
  int   bp_mode = 0;
  logic mem_clr = 1'b1;

  logic [DATA_W-1:0] arr_mem [WORDS];
  logic [DATA_W-1:0] ref_mem [WORDS];

  always @(posedge clk) cyc <= cyc + 1;

  // Array model: sel-gated write on the clock, merged combinational read
  always @(posedge clk) begin
    for (int i = 0; i < WORDS; i++) begin
      if (mem_clr) arr_mem[i] <= DATA_W'(i * 17 + 5);
      else if (arr_sel[i] && arr_rw) arr_mem[i] <= arr_wdata;
    end
  end

  always_comb begin
    arr_rdata = '0;
    for (int i = 0; i < WORDS; i++) if (arr_sel[i]) arr_rdata = arr_rdata | arr_mem[i];
  end

  // Consumer back-pressure: 0 = always ready, 1 = stalled, other = random
  always @(posedge clk) begin
    #1;
    case (bp_mode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = 1'b0;
      default: rsp_ready = ($urandom % 3) != 0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Presents a request (called at posedge+1) and records the prediction when accepted
  task automatic issue(input logic we, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wd, output int acc);
    exp_t e;
    bit   done;
    done = 0;
    acc = -1;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    for (int i = 0; i < 200 && !done; i++) begin
      if (req_ready) begin
        e.we = we; e.addr = addr; e.wdata = wd; e.acc = cyc;
        e.err = int'(addr) >= WORDS;
        e.rdata = '0;
        if (!e.err) begin
          if (we) ref_mem[addr] = wd;
          else    e.rdata = ref_mem[addr];
        end
        sbq.push_back(e);
        acc = cyc;
        done = 1;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (!done) begin
      n_chk++; n_err++;
      $display("FAIL accept_timeout addr=%0d: got no acceptance, required acceptance within 200 cycles", addr);
    end
  endtask

  task automatic drain(input int limit);
    for (int i = 0; i < limit && sbq.size() > 0; i++) begin
      @(posedge clk); #1;
    end
    if (sbq.size() > 0) begin
      n_chk++; n_err++;
      $display("FAIL drain_timeout: got %0d responses outstanding, required 0", sbq.size());
    end
  endtask

  // Monitor: compares every cycle against the in-flight prediction at the queue head
  exp_t             m_e;
  bit               m_have;
  bit               m_valid;
  logic [WORDS-1:0] m_sel;
  always @(negedge clk) begin
    if (rst_n) begin
      m_have = sbq.size() > 0;
      if (m_have) m_e = sbq[0];
      m_sel = '0;
      if (m_have && cyc == m_e.acc + 2 && int'(m_e.addr) < WORDS) m_sel = WORDS'(1) << m_e.addr;
      chk("arr_sel", 32'(arr_sel), 32'(m_sel));
      chk("req_ready", 32'(req_ready), 32'(!m_have || cyc <= m_e.acc));
      m_valid = m_have && cyc >= m_e.acc + 4;
      chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
      if (m_have && cyc >= m_e.acc + 1 && cyc <= m_e.acc + 3) begin
        chk("arr_rw_held", 32'(arr_rw), 32'(m_e.we));
        chk("arr_wdata_held", 32'(arr_wdata), 32'(m_e.wdata));
      end else if (!m_have || cyc <= m_e.acc) begin
        chk("arr_rw_idle", 32'(arr_rw), 32'(0));
        chk("arr_wdata_idle", 32'(arr_wdata), 32'(0));
      end
      if (m_valid && rsp_valid) begin
        chk("rsp_rdata", 32'(rsp_rdata), 32'(m_e.rdata));
        chk("rsp_err", 32'(rsp_err), 32'(m_e.err));
        if (rsp_ready) begin
          hs_cyc = cyc;
          void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    int a, a2, prev;
    for (int i = 0; i < WORDS; i++) ref_mem[i] = DATA_W'(i * 17 + 5);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'(1));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'(0));
    chk("rst_arr_sel",   32'(arr_sel),   32'(0));
    rst_n = 1'b1;
    mem_clr = 1'b0;
    @(posedge clk); #1;

    // Write then read back addr 3
    issue(1'b1, 4'd3, 8'hA5, a);
    issue(1'b0, 4'd3, 8'h00, a);
    drain(50);

    // Back-pressure with a competing request waiting upstream
    bp_mode = 1;
    issue(1'b0, 4'd3, 8'h00, a);
    fork
      begin repeat (14) @(posedge clk); bp_mode = 0; end
      issue(1'b1, 4'd5, 8'h3C, a2);
    join
    chk("accept_after_handshake", 32'(a2), 32'(hs_cyc + 1));
    drain(50);

    // Out-of-range read and write
    issue(1'b0, 4'd13, 8'h00, a);
    issue(1'b1, 4'd14, 8'hFF, a);
    issue(1'b0, 4'd11, 8'h00, a);
    drain(50);

    // Back-to-back alternating write/read at both address extremes
    prev = -1;
    for (int k = 0; k < 8; k++) begin
      issue(!k[0], k[1] ? 4'd11 : 4'd0, 8'($urandom), a);
      if (k > 0) chk("b2b_spacing", 32'(a - prev), 32'(5));
      prev = a;
    end
    drain(50);

    // Reset asserted mid-ACCESS
    issue(1'b0, 4'd2, 8'h00, a);
    @(posedge clk); #2;
    chk("pre_rst_arr_sel", 32'(arr_sel), 32'(12'h004));
    rst_n = 1'b0;
    sbq.delete();
    #1;
    chk("mid_rst_arr_sel",   32'(arr_sel),   32'(0));
    chk("mid_rst_arr_rw",    32'(arr_rw),    32'(0));
    chk("mid_rst_arr_wdata", 32'(arr_wdata), 32'(0));
    chk("mid_rst_req_ready", 32'(req_ready), 32'(1));
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("mid_rst_rsp_rdata", 32'(rsp_rdata), 32'(0));
    chk("mid_rst_rsp_err",   32'(rsp_err),   32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_req_ready", 32'(req_ready), 32'(1));

    // Randomized traffic with random back-pressure
    bp_mode = 2;
    repeat (60) issue(1'($urandom), 4'($urandom), 8'($urandom), a);
    bp_mode = 0;
    drain(300);
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
